// File: rtl/axilite_master.sv
// axilite_master
//   AXI4-Lite initiator. It turns one command from the local command port into
//   one single-beat AXI-Lite write or read, and reports completion on a
//   one-cycle done strobe. Only one transaction is in flight at a time, and
//   the response phase has a timeout.
//
// Ports
//   m_axi_aclk, m_axi_areset  clock, synchronous active-high reset
//   cmd_*                     command request: valid/ready, write flag, address, write data
//   done, done_*              completion strobe, response code, read data, timeout flag
//   m_axi_aw*/w*/b*           AXI-Lite write address, write data and write response channels
//   m_axi_ar*/r*              AXI-Lite read address and read data channels
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | cmd_ready high, waiting for cmd_valid
// WR_AW_W  | awvalid/wvalid outstanding, each tracked separately
// WR_B     | bready high, waiting for bvalid or timeout
// RD_AR    | arvalid outstanding
// RD_R     | rready high, waiting for rvalid or timeout
// DONE     | done strobe high for this single cycle
module axilite_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              m_axi_aclk,
  input  logic              m_axi_areset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              done,
  output logic [1:0]        done_resp,
  output logic [DATA_W-1:0] done_rdata,
  output logic              done_timeout,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  output logic [DATA_W-1:0] m_axi_wdata,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  input  logic [1:0]        m_axi_bresp,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_AW_W = 3'd1;
  localparam logic [2:0] S_WR_B    = 3'd2;
  localparam logic [2:0] S_RD_AR   = 3'd3;
  localparam logic [2:0] S_RD_R    = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);
  localparam logic [1:0]  RESP_TO  = 2'b10;

  logic [2:0]        state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              arvalid_q, arvalid_d;
  logic              bready_q, bready_d;
  logic              rready_q, rready_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic              done_q, done_d;
  logic [1:0]        resp_q, resp_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              timeout_q, timeout_d;

  logic aw_hs, w_hs, ar_hs, b_hs, r_hs;

  assign aw_hs = awvalid_q & m_axi_awready;
  assign w_hs  = wvalid_q & m_axi_wready;
  assign ar_hs = arvalid_q & m_axi_arready;
  assign b_hs  = bready_q & m_axi_bvalid;
  assign r_hs  = rready_q & m_axi_rvalid;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_ready_d = cmd_ready_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    bready_d    = bready_q;
    rready_d    = rready_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    done_d      = 1'b0;
    resp_d      = resp_q;
    rdata_d     = rdata_q;
    timeout_d   = timeout_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_d      = cmd_addr;
          wdata_d     = cmd_wdata;
          cmd_ready_d = 1'b0;
          cnt_d       = '0;
          aw_done_d   = 1'b0;
          w_done_d    = 1'b0;
          if (cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WR_AW_W;
          end else begin
            arvalid_d = 1'b1;
            state_d   = S_RD_AR;
          end
        end
      end
      S_WR_AW_W: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        // a handshake on this edge counts as done already
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          bready_d = 1'b1;
          state_d  = S_WR_B;
        end
      end
      S_WR_B: begin
        if (b_hs) begin
          bready_d  = 1'b0;
          done_d    = 1'b1;
          resp_d    = m_axi_bresp;
          rdata_d   = '0;
          timeout_d = 1'b0;
          state_d   = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          bready_d  = 1'b0;
          done_d    = 1'b1;
          resp_d    = RESP_TO;
          rdata_d   = '0;
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RD_AR: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_R;
        end
      end
      S_RD_R: begin
        if (r_hs) begin
          rready_d  = 1'b0;
          done_d    = 1'b1;
          resp_d    = m_axi_rresp;
          rdata_d   = m_axi_rdata;
          timeout_d = 1'b0;
          state_d   = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          rready_d  = 1'b0;
          done_d    = 1'b1;
          resp_d    = RESP_TO;
          rdata_d   = '0;
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DONE: begin
        cmd_ready_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: begin
        cmd_ready_d = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b1;
      addr_q      <= '0;
      wdata_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      done_q      <= 1'b0;
      resp_q      <= 2'b00;
      rdata_q     <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      bready_q    <= bready_d;
      rready_q    <= rready_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      done_q      <= done_d;
      resp_q      <= resp_d;
      rdata_q     <= rdata_d;
      timeout_q   <= timeout_d;
    end
  end

  // one latched address feeds both channels; only one valid is ever raised
  assign cmd_ready     = cmd_ready_q;
  assign done          = done_q;
  assign done_resp     = resp_q;
  assign done_rdata    = rdata_q;
  assign done_timeout  = timeout_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_rready  = rready_q;

endmodule
